// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the ICache/DCache main-memory arbiter: FSM state
// encoding, grant identifiers and the line-offset width helper.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ISSUE   = 3'd1,
    ARB_RDATA   = 3'd2,
    ARB_WDATA   = 3'd3,
    ARB_DELIVER = 3'd4
  } arb_state_e;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;

  // Number of byte-offset bits inside one cache line.
  function automatic int line_off_width(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

endpackage

// File: rtl/mem_arb_line_buffer.sv
// Line-wide data/mask register with a beat counter; serializes writeback
// lines into beats and assembles refill beats into a line.
module mem_arb_line_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [BEATS*DATA_WIDTH-1:0]   load_line,
  input  logic [BEATS*DATA_WIDTH/8-1:0] load_mask,
  input  logic                          beat_wr,
  input  logic                          beat_adv,
  input  logic [DATA_WIDTH-1:0]         beat_in,
  output logic [BEATS*DATA_WIDTH-1:0]   line,
  output logic [DATA_WIDTH-1:0]         beat_bits,
  output logic [DATA_WIDTH/8-1:0]       beat_mask,
  output logic                          last_beat
);

  localparam int LINE  = BEATS * DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [LINE-1:0]   line_q;
  logic [LINE/8-1:0] mask_q;
  logic [CNT_W-1:0]  cnt;

  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  assign line      = line_q;
  assign beat_bits = line_q[cnt*DATA_WIDTH +: DATA_WIDTH];
  assign beat_mask = mask_q[cnt*(DATA_WIDTH/8) +: DATA_WIDTH/8];

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= '0;
      mask_q <= '0;
      cnt    <= '0;
    end else if (load) begin
      line_q <= load_line;
      mask_q <= load_mask;
      cnt    <= '0;
    end else if (beat_wr || beat_adv) begin
      if (beat_wr) begin
        line_q[cnt*DATA_WIDTH +: DATA_WIDTH] <= beat_in;
      end
      // Counter wraps to zero on the last beat so the next line starts clean.
      cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between ICache refills
// and DCache refills/writebacks, one whole-line transaction at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ic_req_valid,
  output logic                          ic_req_ready,
  input  logic [ADDR_WIDTH-1:0]         ic_req_addr,
  output logic                          ic_resp_valid,
  output logic [BEATS*DATA_WIDTH-1:0]   ic_resp_data,
  input  logic                          dc_req_valid,
  output logic                          dc_req_ready,
  input  logic                          dc_req_rnw,
  input  logic [ADDR_WIDTH-1:0]         dc_req_addr,
  input  logic [BEATS*DATA_WIDTH-1:0]   dc_req_wdata,
  input  logic [BEATS*DATA_WIDTH/8-1:0] dc_req_wmask,
  output logic                          dc_resp_valid,
  output logic [BEATS*DATA_WIDTH-1:0]   dc_resp_data,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic                          mem_req_rnw,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic                          mem_req_data_valid,
  input  logic                          mem_req_data_ready,
  output logic [DATA_WIDTH-1:0]         mem_req_data_bits,
  output logic [DATA_WIDTH/8-1:0]       mem_req_data_mask,
  input  logic                          mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_resp_data
);

  localparam int LINE  = BEATS * DATA_WIDTH;
  localparam int OFF_W = line_off_width(LINE);
  localparam logic [ADDR_WIDTH-1:0] LINE_ALIGN = ~ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and ready may depend on valid.
  arb_state_e            state, state_next;
  logic                  last_grant, owner, rnw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  grant_dc, grant_ic, accept;
  logic                  beat_wr, beat_adv, last_beat;
  logic [LINE-1:0]       line;
  logic [DATA_WIDTH-1:0] beat_bits;
  logic [DATA_WIDTH/8-1:0] beat_mask;

  assign grant_dc     = dc_req_valid && (!ic_req_valid || last_grant == GRANT_IC);
  assign grant_ic     = ic_req_valid && !grant_dc;
  assign ic_req_ready = (state == ARB_IDLE) && grant_ic;
  assign dc_req_ready = (state == ARB_IDLE) && grant_dc;
  assign accept       = (ic_req_valid && ic_req_ready) || (dc_req_valid && dc_req_ready);

  mem_arb_line_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BEATS     (BEATS)
  ) u_line_buffer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_line(grant_dc ? dc_req_wdata : '0),
    .load_mask(grant_dc ? dc_req_wmask : '0),
    .beat_wr  (beat_wr),
    .beat_adv (beat_adv),
    .beat_in  (mem_resp_data),
    .line     (line),
    .beat_bits(beat_bits),
    .beat_mask(beat_mask),
    .last_beat(last_beat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_IC;
      owner      <= GRANT_IC;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner      <= grant_dc ? GRANT_DC : GRANT_IC;
        last_grant <= grant_dc ? GRANT_DC : GRANT_IC;
        rnw_q      <= grant_dc ? dc_req_rnw : 1'b1;
        addr_q     <= grant_dc ? dc_req_addr : ic_req_addr;
      end
    end
  end

  always_comb begin
    state_next         = state;
    mem_req_valid      = 1'b0;
    mem_req_rnw        = 1'b0;
    mem_req_addr       = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;
    ic_resp_valid      = 1'b0;
    ic_resp_data       = '0;
    dc_resp_valid      = 1'b0;
    dc_resp_data       = '0;
    beat_wr            = 1'b0;
    beat_adv           = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (accept) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_req_rnw   = rnw_q;
        mem_req_addr  = addr_q & LINE_ALIGN;
        if (mem_req_ready) state_next = rnw_q ? ARB_RDATA : ARB_WDATA;
      end
      ARB_WDATA: begin
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = beat_bits;
        mem_req_data_mask  = beat_mask;
        if (mem_req_data_ready) begin
          beat_adv = 1'b1;
          if (last_beat) state_next = ARB_DELIVER;
        end
      end
      ARB_RDATA: begin
        if (mem_resp_valid) begin
          beat_wr = 1'b1;
          if (last_beat) state_next = ARB_DELIVER;
        end
      end
      ARB_DELIVER: begin
        // Writes are acknowledged with an all-zero line.
        if (owner == GRANT_DC) begin
          dc_resp_valid = 1'b1;
          dc_resp_data  = rnw_q ? line : '0;
        end else begin
          ic_resp_valid = 1'b1;
          ic_resp_data  = line;
        end
        state_next = ARB_IDLE;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  resp_only_in_rdata: assert property (
    @(posedge clk) disable iff (reset) mem_resp_valid |-> state == ARB_RDATA
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a round-robin/line model.
module tb_mem_arbiter;

  localparam int AW = 32, DW = 128, BEATS = 4, LINE = DW * BEATS;

  logic            clk = 1'b0;
  logic            reset;
  logic            ic_req_valid, ic_req_ready;
  logic [AW-1:0]   ic_req_addr;
  logic            ic_resp_valid;
  logic [LINE-1:0] ic_resp_data;
  logic            dc_req_valid, dc_req_ready, dc_req_rnw;
  logic [AW-1:0]   dc_req_addr;
  logic [LINE-1:0] dc_req_wdata;
  logic [LINE/8-1:0] dc_req_wmask;
  logic            dc_resp_valid;
  logic [LINE-1:0] dc_resp_data;
  logic            mem_req_valid, mem_req_ready, mem_req_rnw;
  logic [AW-1:0]   mem_req_addr;
  logic            mem_req_data_valid, mem_req_data_ready;
  logic [DW-1:0]   mem_req_data_bits;
  logic [DW/8-1:0] mem_req_data_mask;
  logic            mem_resp_valid;
  logic [DW-1:0]   mem_resp_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_last;  // 0 = IC granted last, 1 = DC granted last

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rnw(dc_req_rnw),
    .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data_valid(mem_req_data_valid),
    .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
    .mem_req_data_mask(mem_req_data_mask), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE-1:0] act, input logic [LINE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LINE-1:0] rand_line();
    logic [LINE-1:0] l;
    for (int i = 0; i < LINE / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
    return (a / 64) * 64;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_last = 1'b0;
  endtask

  // Presents a request, checks readies against the round-robin model, and
  // returns at the negedge after the accepting edge with the inputs scrambled.
  task automatic request(input logic ic_v, input logic dc_v, input logic rnw,
                         input logic [AW-1:0] ic_a, input logic [AW-1:0] dc_a,
                         input logic [LINE-1:0] wd, input logic [LINE/8-1:0] wm,
                         output logic dc_won);
    logic exp_dc;
    exp_dc = dc_v && (!ic_v || model_last == 1'b0);
    ic_req_valid = ic_v;  ic_req_addr = ic_a;
    dc_req_valid = dc_v;  dc_req_rnw  = rnw;  dc_req_addr = dc_a;
    dc_req_wdata = wd;    dc_req_wmask = wm;
    #1;
    check("ic_req_ready", ic_req_ready, ic_v && !exp_dc);
    check("dc_req_ready", dc_req_ready, exp_dc);
    dc_won     = exp_dc;
    model_last = exp_dc;
    @(negedge clk);
    ic_req_valid = 1'b0;  dc_req_valid = 1'b0;
    ic_req_addr  = $urandom;  dc_req_addr = $urandom;  dc_req_rnw = ~rnw;
    dc_req_wdata = rand_line();  dc_req_wmask = rand_line();
  endtask

  // Acts as main memory for one accepted transaction and checks the response.
  task automatic serve(input logic dc_own, input logic rnw, input logic [AW-1:0] exp_addr,
                       input logic [LINE-1:0] wline, input logic [LINE/8-1:0] wmask,
                       input logic [LINE-1:0] rline, input int req_delay,
                       input int stall_beat, input int stall_cyc, input int rgap,
                       input logic b2b);
    #1;
    check("issue_latency", mem_req_valid, 1'b1);
    for (int d = 0; d < req_delay; d++) begin
      mem_req_ready = 1'b0;
      #1;
      check("hold_valid", mem_req_valid, 1'b1);
      check("hold_addr", mem_req_addr, exp_addr);
      check("no_data_early", mem_req_data_valid, 1'b0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    check("req_valid", mem_req_valid, 1'b1);
    check("req_addr", mem_req_addr, exp_addr);
    check("req_rnw", mem_req_rnw, rnw);
    @(negedge clk);
    mem_req_ready = 1'b0;
    if (!rnw) begin
      for (int b = 0; b < BEATS; b++) begin
        for (int s = 0; s < ((b == stall_beat) ? stall_cyc : 0); s++) begin
          mem_req_data_ready = 1'b0;
          #1;
          check("wbeat_hold_valid", mem_req_data_valid, 1'b1);
          check("wbeat_hold_bits", mem_req_data_bits, wline[b*DW +: DW]);
          @(negedge clk);
        end
        mem_req_data_ready = 1'b1;
        #1;
        check("wbeat_valid", mem_req_data_valid, 1'b1);
        check("wbeat_bits", mem_req_data_bits, wline[b*DW +: DW]);
        check("wbeat_mask", mem_req_data_mask, wmask[b*(DW/8) +: DW/8]);
        @(negedge clk);
        mem_req_data_ready = 1'b0;
      end
    end else begin
      for (int b = 0; b < BEATS; b++) begin
        if (b == 1 || b == 3) begin
          for (int g = 0; g < rgap; g++) begin
            #1;
            check("rd_gap_no_resp", ic_resp_valid | dc_resp_valid, 1'b0);
            @(negedge clk);
          end
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = rline[b*DW +: DW];
        #1;
        check("rd_no_wdata", mem_req_data_valid, 1'b0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
      end
    end
    if (b2b) dc_req_valid = 1'b1;
    #1;
    check("resp_valid_ic", ic_resp_valid, !dc_own);
    check("resp_valid_dc", dc_resp_valid, dc_own);
    check("resp_data", dc_own ? dc_resp_data : ic_resp_data, rnw ? rline : '0);
    if (b2b) check("no_accept_in_deliver", dc_req_ready, 1'b0);
    @(negedge clk);
    #1;
    check("resp_one_cycle", ic_resp_valid | dc_resp_valid, 1'b0);
    if (b2b) begin
      check("b2b_accept_idle", dc_req_ready, 1'b1);
      model_last = 1'b1;
      @(negedge clk);
      dc_req_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic        dc;
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] exp_maddr;
    logic [DW-1:0] base;
    logic [DW-1:0] step;
    int          req_delay;
    int          stall_beat;
    int          stall_cyc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [LINE-1:0]   line;
    logic [LINE/8-1:0] wm;
    logic              won;

    vecs[0] = '{1'b0, 1'b1, 32'h1000_0024, 32'h1000_0000, 128'hA0,   128'h1,    0, 0, 0};
    vecs[1] = '{1'b1, 1'b0, 32'h2000_007F, 32'h2000_0040, 128'h1111, 128'h1111, 0, 1, 2};
    vecs[2] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 128'h55,   128'h3,    5, 0, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_003F, 32'h0000_0000, 128'h7,    128'h100,  1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 128'hBEEF, 128'h2,    2, 3, 1};

    reset = 1'b1;
    ic_req_valid = 0; ic_req_addr = 0; dc_req_valid = 0; dc_req_rnw = 0;
    dc_req_addr = 0; dc_req_wdata = 0; dc_req_wmask = 0;
    mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    model_last = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ic_ready", ic_req_ready, 1'b0);
    check("rst_dc_ready", dc_req_ready, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_mem_addr", mem_req_addr, '0);
    check("rst_data_valid", mem_req_data_valid, 1'b0);
    check("rst_data_bits", mem_req_data_bits, '0);
    check("rst_ic_resp", ic_resp_valid, 1'b0);
    check("rst_dc_resp", dc_resp_valid, 1'b0);
    check("rst_resp_data", ic_resp_data | dc_resp_data, '0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    foreach (vecs[i]) begin
      for (int b = 0; b < BEATS; b++) line[b*DW +: DW] = vecs[i].base + vecs[i].step * b;
      wm = '1;
      request(!vecs[i].dc, vecs[i].dc, vecs[i].rnw, vecs[i].addr, vecs[i].addr,
              line, wm, won);
      serve(vecs[i].dc, vecs[i].rnw | !vecs[i].dc, vecs[i].exp_maddr, line, wm, line,
            vecs[i].req_delay, vecs[i].stall_beat, vecs[i].stall_cyc, 0, 1'b0);
    end

    // Ties after reset: DC, IC, DC
    do_reset();
    for (int t = 0; t < 3; t++) begin
      line = rand_line();
      request(1'b1, 1'b1, 1'b1, 32'h0000_1000 + t, 32'h0000_2000 + t, '0, '0, won);
      serve(won, 1'b1, won ? 32'h0000_2000 : 32'h0000_1000, '0, '0, line, 0, 0, 0, 1, 1'b0);
    end

    // Reset during read beat 2, then a fresh read
    request(1'b1, 1'b0, 1'b1, 32'h0000_4000, '0, '0, '0, won);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_resp_valid = 1'b1; mem_resp_data = 128'hDEAD + b;
      @(negedge clk);
    end
    mem_resp_data = 128'hDEAD2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_last = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rst_mid_no_resp", ic_resp_valid | dc_resp_valid, 1'b0);
      check("rst_mid_no_mem", mem_req_valid, 1'b0);
      @(negedge clk);
    end
    line = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
    request(1'b1, 1'b0, 1'b1, 32'h0000_4010, '0, '0, '0, won);
    serve(1'b0, 1'b1, 32'h0000_4000, '0, '0, line, 0, 0, 0, 0, 1'b0);

    // Back-to-back: DC write then DC read held pending through DELIVER
    line = rand_line();
    wm = rand_line();
    request(1'b0, 1'b1, 1'b0, '0, 32'h0000_8008, line, wm, won);
    dc_req_rnw = 1'b1; dc_req_addr = 32'h0000_9044;
    serve(1'b1, 1'b0, 32'h0000_8000, line, wm, '0, 0, 0, 0, 0, 1'b1);
    line = rand_line();
    serve(1'b1, 1'b1, 32'h0000_9040, '0, '0, line, 0, 0, 0, 0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      logic icv, dcv, rnw;
      logic [AW-1:0] ia, da;
      logic [LINE-1:0] wl, rl;
      logic [LINE/8-1:0] msk;
      icv = $urandom_range(0, 1);
      dcv = $urandom_range(0, 1);
      if (!icv && !dcv) dcv = 1'b1;
      rnw = $urandom_range(0, 1);
      ia = $urandom; da = $urandom;
      wl = rand_line(); rl = rand_line(); msk = rand_line();
      request(icv, dcv, rnw, ia, da, wl, msk, won);
      serve(won, won ? rnw : 1'b1, line_base(won ? da : ia), wl, msk, rl,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 2), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
